// File: rtl/player_pkg.sv
// player_pkg: shared state encoding and USB keycodes for the player motion block
package player_pkg;
  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
endpackage

// File: rtl/player_motion_ctrl_if.sv
// player_motion_ctrl_if: keyboard/contact inputs and motion outputs of the player controller
interface player_motion_ctrl_if;
  logic [7:0] keycode;
  logic       floor_hit;
  logic       ceil_hit;
  logic [9:0] X_Motion;
  logic [9:0] Y_Motion;
  logic [1:0] state;
  logic [1:0] jumps_used;
  modport master (output keycode, floor_hit, ceil_hit, input X_Motion, Y_Motion, state, jumps_used);
  modport slave (input keycode, floor_hit, ceil_hit, output X_Motion, Y_Motion, state, jumps_used);
endinterface

// File: rtl/player_motion_ctrl_key_edge_detect.sv
// key_edge_detect: one-cycle pulse when the jump key goes from released to pressed
module key_edge_detect
  import player_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  output logic       jump_edge
);
  logic [7:0] prev_key;
  always_ff @(posedge frame_clk)
    prev_key <= !Reset_n ? 8'h00 : keycode;
  assign jump_edge = keycode == KEY_W && prev_key != KEY_W;
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: walk/jump/gravity FSM producing per-frame X/Y steps
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int WALK_STEP   = 1,
  parameter int JUMP_VEL    = 8,
  parameter int GRAVITY_DIV = 2,
  parameter int MAX_FALL    = 8,
  parameter int MAX_JUMPS   = 2
) (
  input logic frame_clk,
  input logic Reset_n,
  player_motion_ctrl_if.slave bus
);
  localparam logic [1:0] S_GROUND = GROUND;
  localparam logic [1:0] S_RISE   = RISE;
  localparam logic [1:0] S_FALL   = FALL;
  localparam logic [9:0] WS_P  = 10'(WALK_STEP);
  localparam logic [9:0] WS_N  = 10'(-WALK_STEP);
  localparam logic [9:0] JV_N  = 10'(-JUMP_VEL);
  localparam logic [9:0] MF    = 10'(MAX_FALL);
  localparam logic [7:0] GD_M1 = 8'(GRAVITY_DIV - 1);
  localparam logic [1:0] MJ    = 2'(MAX_JUMPS);
  logic       jump_edge, wrap, can_jump;
  logic [1:0] st_n, ju_n;
  logic [9:0] x_n, y_n, y_inc;
  logic [7:0] grav_cnt, gc_n;
  key_edge_detect u_edge (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode   (bus.keycode),
    .jump_edge (jump_edge)
  );
  always_comb begin
    y_inc    = bus.Y_Motion + 10'd1;
    wrap     = grav_cnt == GD_M1;
    can_jump = jump_edge && bus.jumps_used < MJ;
    x_n      = bus.keycode == KEY_A ? WS_N : bus.keycode == KEY_D ? WS_P : 10'd0;
    st_n     = bus.state;
    y_n      = bus.Y_Motion;
    ju_n     = bus.jumps_used;
    gc_n     = wrap ? 8'd0 : grav_cnt + 8'd1;
    case (bus.state)
      S_GROUND: begin
        gc_n = 8'd0;
        y_n  = jump_edge ? JV_N : 10'd0;
        ju_n = jump_edge ? 2'd1 : 2'd0;
        st_n = jump_edge ? S_RISE : !bus.floor_hit ? S_FALL : S_GROUND;
      end
      S_RISE: begin
        if (bus.ceil_hit) begin
          st_n = S_FALL;
          y_n  = 10'd0;
          gc_n = 8'd0;
        end else if (can_jump) begin
          y_n  = JV_N;
          ju_n = bus.jumps_used + 2'd1;
          gc_n = 8'd0;
        end else if (wrap) begin
          y_n  = y_inc;
          st_n = y_inc == 10'd0 ? S_FALL : S_RISE;
        end
      end
      S_FALL: begin
        if (bus.floor_hit) begin
          st_n = S_GROUND;
          y_n  = 10'd0;
          ju_n = 2'd0;
          gc_n = 8'd0;
        end else if (can_jump) begin
          st_n = S_RISE;
          y_n  = JV_N;
          ju_n = bus.jumps_used + 2'd1;
          gc_n = 8'd0;
        end else if (wrap) begin
          y_n = $signed(bus.Y_Motion) >= $signed(MF) ? MF : y_inc;
        end
      end
      default: begin
        st_n = S_FALL;
        y_n  = 10'd0;
        gc_n = 8'd0;
      end
    endcase
  end
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      bus.state      <= S_GROUND;
      bus.X_Motion   <= 10'd0;
      bus.Y_Motion   <= 10'd0;
      bus.jumps_used <= 2'd0;
      grav_cnt       <= 8'd0;
    end else begin
      bus.state      <= st_n;
      bus.X_Motion   <= x_n;
      bus.Y_Motion   <= y_n;
      bus.jumps_used <= ju_n;
      grav_cnt       <= gc_n;
    end
  end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: scoreboard bench for the player motion FSM at default parameters
module tb_player_motion_ctrl;
  typedef struct {
    string       name;
    logic [23:0] v;
  } exp_t;
  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  int   errors    = 0;
  int   checks    = 0;
  exp_t q[$];
  exp_t e;
  player_motion_ctrl_if bus ();
  player_motion_ctrl dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );
  always #5 frame_clk = ~frame_clk;
  function automatic logic [23:0] pk(int s, int x, int y, int j);
    return {2'(s), 10'(x), 10'(y), 2'(j)};
  endfunction
  function automatic logic [23:0] obs();
    return {bus.state, bus.X_Motion, bus.Y_Motion, bus.jumps_used};
  endfunction
  task automatic step(string n, logic [7:0] k, logic f, logic c, logic [23:0] v);
    bus.keycode   = k;
    bus.floor_hit = f;
    bus.ceil_hit  = c;
    q.push_back('{n, v});
    @(posedge frame_clk);
    #1;
  endtask
  task automatic test_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step("reset_hold", 8'h1A, 1'b1, 1'b0, pk(0, 0, 0, 0));
      e = q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    end
    Reset_n = 1'b1;
    step("after_reset", 8'h00, 1'b1, 1'b0, pk(0, 0, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
  endtask
  task automatic test_single_jump();
    step("jump_press", 8'h1A, 1'b1, 1'b0, pk(1, 0, -8, 1));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    for (int k = 1; k <= 16; k++) begin
      step($sformatf("rise_%0d", k), 8'h00, 1'b0, 1'b0, pk(k == 16 ? 2 : 1, 0, -8 + k / 2, 1));
      e = q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    end
  endtask
  task automatic test_fall_clamp();
    for (int j = 1; j <= 30; j++) begin
      step($sformatf("fall_%0d", j), 8'h00, 1'b0, 1'b0, pk(2, 0, j / 2 > 8 ? 8 : j / 2, 1));
      e = q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    end
    step("land_with_jump", 8'h1A, 1'b1, 1'b0, pk(0, 0, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
  endtask
  task automatic test_held_key();
    int y;
    step("held_prep", 8'h00, 1'b1, 1'b0, pk(0, 0, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    for (int k = 0; k < 40; k++) begin
      y = k <= 16 ? -8 + k / 2 : ((k - 16) / 2 > 8 ? 8 : (k - 16) / 2);
      step($sformatf("held_%0d", k), 8'h1A, 1'b0, 1'b0, pk(k < 16 ? 1 : 2, 0, y, 1));
      e = q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    end
    step("held_land", 8'h1A, 1'b1, 1'b0, pk(0, 0, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
  endtask
  task automatic test_double_jump();
    logic [7:0] kt[9] = '{8'h00, 8'h1A, 8'h00, 8'h00, 8'h1A, 8'h00, 8'h00, 8'h1A, 8'h00};
    int st[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    int yt[9] = '{0, -8, -8, -7, -8, -8, -7, -7, -6};
    int jt[9] = '{0, 1, 1, 1, 2, 2, 2, 2, 2};
    for (int i = 0; i < 9; i++) begin
      step($sformatf("double_%0d", i), kt[i], i == 0, 1'b0, pk(st[i], 0, yt[i], jt[i]));
      e = q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    end
  endtask
  task automatic test_walk_ceiling();
    logic [7:0] kt[9] = '{8'h00, 8'h1A, 8'h00, 8'h04, 8'h07, 8'h16, 8'h00, 8'h1A, 8'h00};
    logic ft[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic ct[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int st[9] = '{2, 2, 0, 0, 0, 0, 0, 1, 2};
    int xt[9] = '{0, 0, 0, -1, 1, 0, 0, 0, 0};
    int yt[9] = '{0, 0, 0, 0, 0, 0, 0, -8, 0};
    int jt[9] = '{2, 2, 0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 9; i++) begin
      step($sformatf("walk_ceil_%0d", i), kt[i], ft[i], ct[i], pk(st[i], xt[i], yt[i], jt[i]));
      e = q.pop_front(); checks++;
      if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    end
  endtask
  task automatic test_reset_mid_jump();
    step("mid_prep", 8'h00, 1'b1, 1'b0, pk(0, 0, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    step("mid_jump", 8'h1A, 1'b0, 1'b0, pk(1, 0, -8, 1));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    Reset_n = 1'b0;
    step("reset_mid_jump", 8'h07, 1'b0, 1'b0, pk(0, 0, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
    Reset_n = 1'b1;
    step("post_reset_walk", 8'h07, 1'b1, 1'b0, pk(0, 1, 0, 0));
    e = q.pop_front(); checks++;
    if (obs() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h (state,X,Y,jumps)", e.name, obs(), e.v); end
  endtask
  initial begin
    bus.keycode   = 8'h00;
    bus.floor_hit = 1'b1;
    bus.ceil_hit  = 1'b0;
    test_reset();
    test_single_jump();
    test_fall_clamp();
    test_held_key();
    test_double_jump();
    test_walk_ceiling();
    test_reset_mid_jump();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d leftover expected 0", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish within 1ms");
    $fatal(1);
  end
endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 SHALL have parameter WALK_STEP, default 1: horizontal speed in pixels/frame.
REQ-002 SHALL have parameter JUMP_VEL, default 8: initial upward speed in pixels/frame.
REQ-003 SHALL have parameter GRAVITY_DIV, default 2: number of frames per +1 change in vertical velocity.
REQ-004 SHALL have parameter MAX_FALL, default 8: maximum downward speed.
REQ-005 SHALL have parameter MAX_JUMPS, default 2: jumps allowed before landing.
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 Port frame_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-008 Port Reset_n, input, 1 bit: synchronous, active-low reset.
REQ-009 Port keycode, input, 8 bits: current USB keycode.
REQ-010 Port floor_hit, input, 1 bit: the position datapath reports bottom contact.
REQ-011 Port ceil_hit, input, 1 bit: the position datapath reports top contact.
REQ-012 Port X_Motion, output, 10 bits: two's-complement horizontal step.
REQ-013 Port Y_Motion, output, 10 bits: two's-complement vertical step; positive is down.
REQ-014 Port state, output, 2 bits: current FSM state (GROUND=0, RISE=1, FALL=2).
REQ-015 Port jumps_used, output, 2 bits: jumps taken since last landing.

Function
REQ-016 All outputs SHALL be registered, with 1-cycle latency from input to output.
REQ-017 X_Motion SHALL be set as follows; keycode is only one code, so keys never coincide.
- keycode 8'h04 (A): -WALK_STEP.
- keycode 8'h07 (D): +WALK_STEP.
- Any other keycode: 0.
- X_Motion is independent of state.
REQ-018 jump_edge SHALL be 1 only when keycode==8'h1A and the previous-cycle keycode!=8'h1A; holding the key SHALL yield one edge.
REQ-019 GROUND state SHALL behave as follows:
- Y_Motion=0.
- jump_edge -> RISE, with Y_Motion=-JUMP_VEL and jumps_used=1.
- Else floor_hit=0 -> FALL, with Y_Motion=0 and jumps_used=0.
REQ-020 RISE and FALL SHALL share gravity handling:
- grav_cnt counts 0..GRAVITY_DIV-1.
- When grav_cnt wraps to 0, Y_Motion increments by 1.
- grav_cnt clears on every state entry and on every jump.
REQ-021 RISE state SHALL behave as follows:
- ceil_hit -> FALL with Y_Motion=0.
- Else if the gravity increment makes Y_Motion reach 0 -> FALL.
- jump_edge with jumps_used<MAX_JUMPS reloads Y_Motion=-JUMP_VEL, increments jumps_used, and stays in RISE.
REQ-022 FALL state SHALL behave as follows:
- floor_hit -> GROUND with Y_Motion=0 and jumps_used=0.
- Else jump_edge with jumps_used<MAX_JUMPS -> RISE with Y_Motion=-JUMP_VEL and jumps_used+1.
- Else apply gravity, saturating Y_Motion at +MAX_FALL.
REQ-023 Priority in FALL SHALL be floor_hit > jump_edge > gravity; a jump_edge in the landing cycle is discarded.
REQ-024 Priority in RISE SHALL be ceil_hit > jump_edge > gravity.
REQ-025 A jump_edge with jumps_used==MAX_JUMPS SHALL be ignored.
REQ-026 Encoding 3 of state SHALL be unreachable; if entered it SHALL return to FALL with Y_Motion=0.

Reset
REQ-027 While Reset_n=0 at a clock edge, the block SHALL load:
- state=GROUND.
- X_Motion=0 and Y_Motion=0.
- jumps_used=0 and grav_cnt=0.
- Previous keycode=8'h00.
REQ-028 Reset SHALL override all other events, including reset mid-jump.

Structure
REQ-029 Package player_pkg SHALL hold:
- The state enum (GROUND, RISE, FALL).
- KEY_W=8'h1A, KEY_A=8'h04, KEY_S=8'h16, KEY_D=8'h07.
REQ-030 Sub-module key_edge_detect SHALL register keycode and produce jump_edge; everything else stays in player_motion_ctrl.

Verification (default parameters)
REQ-031 Reset: hold Reset_n=0 for 2 cycles with keycode=8'h1A -> state=0, X_Motion=0, Y_Motion=0, jumps_used=0.
REQ-032 Single jump: hold floor_hit=1, then pulse keycode=8'h1A for 1 cycle, then set floor_hit=0 ->
- Next cycle: state=RISE and Y_Motion=10'h3F8 (-8).
- Y_Motion then rises by 1 every 2 frames.
- 16 frames after the jump: Y_Motion=0 and state=FALL.
REQ-033 Held key: hold keycode=8'h1A for 40 frames from GROUND -> jumps_used=1; no reload to -8 after the first.
REQ-034 Double-jump limit: from GROUND, press and release 8'h1A three times while airborne ->
- First two presses reload Y_Motion=-8; jumps_used=2.
- Third press is ignored.
REQ-035 Fall clamp and landing: FALL for 30 frames -> Y_Motion saturates at 8; then assert floor_hit together with a keycode 8'h1A edge -> state=GROUND, Y_Motion=0, jumps_used=0.
REQ-036 Walking, ceiling, and reset mid-jump:
- keycode 8'h04 -> X_Motion=10'h3FF; 8'h07 -> X_Motion=1.
- ceil_hit in RISE -> FALL with Y_Motion=0.
- Reset_n=0 in RISE -> GROUND on the next cycle.
